avg3x3_line_sched: RTL and testbench



---
 rtl/avg3x3_pkg.sv | 20 ++
 rtl/avg3x3_line_buf.sv | 25 ++
 rtl/avg3x3_line_sched.sv | 190 +++++++++++++++++++
 tb/tb_avg3x3_line_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/avg3x3_pkg.sv
// rtl/avg3x3_pkg.sv - shared types and constants for the 3x3 average line sequencer
package avg3x3_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    RUN,
    GAP,
    FLUSH
  } state_t;

  localparam int DW_DEC_DEFAULT = 8;
  localparam int PIX_W          = DW_DEC_DEFAULT + 1;
  localparam int MIN_LINE_GAP   = 2;

  function automatic int pix_width(input int dw_dec);
    return dw_dec + 1;
  endfunction

endpackage

// File: rtl/avg3x3_line_buf.sv
// rtl/avg3x3_line_buf.sv - one-line register array, async read, read-before-write
module avg3x3_line_buf
  import avg3x3_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = PIX_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read is combinational from the array, so a same-cycle write is seen next cycle.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/avg3x3_line_sched.sv
// rtl/avg3x3_line_sched.sv - 3x3 average filter front-end: line buffers, taps, framing, flush
// Optional AVG3X3_RUNTIME_SIZE_EN: adds cfg_w_i/cfg_h_i sampled on frame_start.
module avg3x3_line_sched
  import avg3x3_pkg::*;
#(
  parameter int DW_DEC    = DW_DEC_DEFAULT,
  parameter int IMG_W     = 64,
  parameter int IMG_H     = 48,
  parameter int FLUSH_GAP = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          pix_valid,
  input  logic [DW_DEC:0] pix_in,
`ifdef AVG3X3_RUNTIME_SIZE_EN
  input  logic [15:0]   cfg_w_i,
  input  logic [15:0]   cfg_h_i,
`endif
  output logic [DW_DEC:0] in1_o,
  output logic [DW_DEC:0] in2_o,
  output logic [DW_DEC:0] in3_o,
  output logic          filter_start_o,
  output logic          filter_end_o,
  output logic          frame_done_o,
  output logic          busy_o,
  output logic          err_o
);

  localparam int PW = pix_width(DW_DEC);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int GW = $clog2(FLUSH_GAP);

  state_t        state;
  logic [XW-1:0] x;
  logic [XW-1:0] w_last;
  logic [YW-1:0] y;
  logic [YW-1:0] h_last;
  logic [GW-1:0] gap_cnt;
  logic          sel;
  logic          flush_last;
  logic          start_ok;
  logic          wsel;
  logic          accept;
  logic [XW-1:0] addr;
  logic [PW-1:0] rd_a;
  logic [PW-1:0] rd_b;
  logic [PW-1:0] rd_prev;
  logic [PW-1:0] rd_old;

`ifdef AVG3X3_RUNTIME_SIZE_EN
  assign start_ok = (cfg_w_i >= 16'd2) && (cfg_h_i >= 16'd2) &&
                    (cfg_w_i <= 16'(IMG_W)) && (cfg_h_i <= 16'(IMG_H));
`else
  assign start_ok = 1'b1;
  assign w_last   = XW'(IMG_W - 1);
  assign h_last   = YW'(IMG_H - 1);
`endif

  // A frame_start beat restarts at row 0, x=0 in buffer A regardless of where we were.
  assign accept = pix_valid && (frame_start ? start_ok : (state == FILL || state == RUN));
  assign wsel   = frame_start ? 1'b0 : sel;
  assign addr   = frame_start ? '0 : x;

  // sel names the buffer being written; the other one holds the previous row.
  assign rd_prev = sel ? rd_a : rd_b;
  assign rd_old  = sel ? rd_b : rd_a;
  assign busy_o  = (state != IDLE);

  avg3x3_line_buf #(.DEPTH(IMG_W), .WIDTH(PW), .AW(XW)) u_lb_a (
    .clk   (clk),
    .we    (accept && !wsel),
    .addr  (addr),
    .wdata (pix_in),
    .rdata (rd_a)
  );

  avg3x3_line_buf #(.DEPTH(IMG_W), .WIDTH(PW), .AW(XW)) u_lb_b (
    .clk   (clk),
    .we    (accept && wsel),
    .addr  (addr),
    .wdata (pix_in),
    .rdata (rd_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      x              <= '0;
      y              <= '0;
      gap_cnt        <= '0;
      sel            <= 1'b0;
      flush_last     <= 1'b0;
      in1_o          <= '0;
      in2_o          <= '0;
      in3_o          <= '0;
      filter_start_o <= 1'b0;
      filter_end_o   <= 1'b0;
      frame_done_o   <= 1'b0;
      err_o          <= 1'b0;
`ifdef AVG3X3_RUNTIME_SIZE_EN
      w_last         <= XW'(IMG_W - 1);
      h_last         <= YW'(IMG_H - 1);
`endif
    end else begin
      filter_start_o <= 1'b0;
      filter_end_o   <= 1'b0;
      flush_last     <= 1'b0;
      frame_done_o   <= flush_last;
      if (frame_start) begin
        // Only a start from IDLE with a legal size leaves the error flag clear.
        err_o   <= (state != IDLE) || !start_ok;
        x       <= '0;
        y       <= '0;
        sel     <= 1'b0;
        gap_cnt <= '0;
        if (!start_ok) begin
          state <= IDLE;
        end else begin
          state <= FILL;
`ifdef AVG3X3_RUNTIME_SIZE_EN
          w_last <= XW'(cfg_w_i - 16'd1);
          h_last <= YW'(cfg_h_i - 16'd1);
`endif
          if (pix_valid) x <= XW'(1);
        end
      end else begin
        unique case (state)
          IDLE: begin
            if (pix_valid) err_o <= 1'b1;
          end
          FILL, RUN: begin
            if (pix_valid) begin
              if (state == RUN) begin
                in1_o          <= (y == YW'(1)) ? rd_prev : rd_old;
                in2_o          <= rd_prev;
                in3_o          <= pix_in;
                filter_start_o <= (x == '0);
                filter_end_o   <= (x == w_last);
              end
              if (x == w_last) begin
                x   <= '0;
                sel <= ~sel;
                if (y == h_last) begin
                  y     <= '0;
                  state <= GAP;
                end else begin
                  y     <= y + 1'b1;
                  state <= RUN;
                end
              end else begin
                x <= x + 1'b1;
              end
            end else if (x != '0) begin
              err_o <= 1'b1;
            end
          end
          GAP: begin
            if (pix_valid) err_o <= 1'b1;
            if (gap_cnt == GW'(FLUSH_GAP - 1)) begin
              gap_cnt <= '0;
              state   <= FLUSH;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          FLUSH: begin
            // Last row is replicated below itself; the row above sits in the older buffer.
            if (pix_valid) err_o <= 1'b1;
            in1_o          <= rd_old;
            in2_o          <= rd_prev;
            in3_o          <= rd_prev;
            filter_start_o <= (x == '0);
            filter_end_o   <= (x == w_last);
            if (x == w_last) begin
              x          <= '0;
              state      <= IDLE;
              flush_last <= 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_avg3x3_line_sched.sv
// tb/tb_avg3x3_line_sched.sv - self-checking bench for avg3x3_line_sched (4x3 frames)
module tb_avg3x3_line_sched;
  import avg3x3_pkg::*;

  localparam int W        = 4;
  localparam int H        = 3;
  localparam int FG       = 4;
  localparam int DW       = 8;
  localparam int PW       = DW + 1;
  localparam int LINE_GAP = MIN_LINE_GAP + 1;
  localparam int TAIL     = FG + W + 4;

  typedef struct packed {
    logic [DW:0] a;
    logic [DW:0] b;
    logic [DW:0] c;
    logic        fs;
    logic        fe;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [DW:0]   pix_in = '0;
  logic [DW:0]   in1_o, in2_o, in3_o;
  logic          filter_start_o, filter_end_o, frame_done_o, busy_o, err_o;

  int            cyc = 0;
  int            n_vec = 0;
  int            n_fail = 0;
  exp_t          exp_m [int];
  bit            done_m [int];
  logic [DW:0]   rows [H][W];
  int            m_row = 0;
  int            m_x = 0;
  bit            m_active = 1'b0;
  int            r1p0 = -1;
  exp_t          ce;
  logic [3*PW-1:0] fs_log [$];
  logic [3*PW-1:0] fe_log [$];
  int            fs_cyc [$];
  int            fe_cyc [$];
  int            done_cyc [$];

  avg3x3_line_sched #(.DW_DEC(DW), .IMG_W(W), .IMG_H(H), .FLUSH_GAP(FG)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .frame_start    (frame_start),
    .pix_valid      (pix_valid),
    .pix_in         (pix_in),
`ifdef AVG3X3_RUNTIME_SIZE_EN
    .cfg_w_i        (16'(W)),
    .cfg_h_i        (16'(H)),
`endif
    .in1_o          (in1_o),
    .in2_o          (in2_o),
    .in3_o          (in3_o),
    .filter_start_o (filter_start_o),
    .filter_end_o   (filter_end_o),
    .frame_done_o   (frame_done_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, want);
    end
  endtask

  function automatic logic [DW:0] pv(input int seed, input int r, input int x);
    return PW'(seed * 37 + r * W + x + 1);
  endfunction

  // Model: row r input at column x yields output row r-1 one cycle later, with
  // top/bottom rows replicated; the flush row follows FG idle cycles after the last input.
  task automatic drive_pix(input logic fs, input logic [DW:0] p);
    exp_t e;
    @(posedge clk);
    #1;
    frame_start = fs;
    pix_valid   = 1'b1;
    pix_in      = p;
    if (fs) begin
      m_active = 1'b1;
      m_row    = 0;
      m_x      = 0;
    end
    if (m_active) begin
      rows[m_row][m_x] = p;
      if (m_row >= 1) begin
        e.a  = rows[(m_row == 1) ? 0 : m_row - 2][m_x];
        e.b  = rows[m_row - 1][m_x];
        e.c  = p;
        e.fs = (m_x == 0);
        e.fe = (m_x == W - 1);
        exp_m[cyc + 1] = e;
        if (m_row == 1 && m_x == 0 && r1p0 < 0) r1p0 = cyc;
      end
      m_x++;
      if (m_x == W) begin
        m_x = 0;
        m_row++;
        if (m_row == H) begin
          m_active = 1'b0;
          for (int k = 0; k < W; k++) begin
            e.a  = rows[H - 2][k];
            e.b  = rows[H - 1][k];
            e.c  = rows[H - 1][k];
            e.fs = (k == 0);
            e.fe = (k == W - 1);
            exp_m[cyc + 2 + FG + k] = e;
          end
          done_m[cyc + FG + W + 2] = 1'b1;
        end
      end
    end
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      pix_valid   = 1'b0;
    end
  endtask

  task automatic send_frame(input int seed, input int drop_r, input int drop_x, input int tail);
    for (int r = 0; r < H; r++) begin
      for (int x = 0; x < W; x++) begin
        if (r == drop_r && x == drop_x) drive_idle(1);
        drive_pix(r == 0 && x == 0, pv(seed, r, x));
      end
      drive_idle((r == H - 1) ? tail : LINE_GAP);
    end
  endtask

  always @(negedge clk) begin
    if (exp_m.exists(cyc)) begin
      ce = exp_m[cyc];
      check("tap_in1", 32'(in1_o), 32'(ce.a));
      check("tap_in2", 32'(in2_o), 32'(ce.b));
      check("tap_in3", 32'(in3_o), 32'(ce.c));
      check("filter_start", 32'(filter_start_o), 32'(ce.fs));
      check("filter_end", 32'(filter_end_o), 32'(ce.fe));
    end else begin
      check("stray_filter_start", 32'(filter_start_o), 32'd0);
      check("stray_filter_end", 32'(filter_end_o), 32'd0);
    end
    check("frame_done", 32'(frame_done_o), 32'(done_m.exists(cyc)));
    if (filter_start_o) begin
      fs_log.push_back({in1_o, in2_o, in3_o});
      fs_cyc.push_back(cyc);
    end
    if (filter_end_o) begin
      fe_log.push_back({in1_o, in2_o, in3_o});
      fe_cyc.push_back(cyc);
    end
    if (frame_done_o) done_cyc.push_back(cyc);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_err", 32'(err_o), 32'd0);
    check("reset_in1", 32'(in1_o), 32'd0);
    check("reset_in3", 32'(in3_o), 32'd0);
    rst_n = 1'b1;
    drive_idle(2);

    // Clean frame with the test-plan pixels 1..12.
    send_frame(0, -1, -1, TAIL);
    check("fs_count", 32'(fs_log.size()), 32'd3);
    check("fe_count", 32'(fe_log.size()), 32'd3);
    check("row0_x0_taps", 32'((fs_log.size() > 0) ? fs_log[0] : '1), 32'({9'd1, 9'd1, 9'd5}));
    check("row0_x3_taps", 32'((fe_log.size() > 0) ? fe_log[0] : '1), 32'({9'd4, 9'd4, 9'd8}));
    check("row1_x0_taps", 32'((fs_log.size() > 1) ? fs_log[1] : '1), 32'({9'd1, 9'd5, 9'd9}));
    check("row1_x3_taps", 32'((fe_log.size() > 1) ? fe_log[1] : '1), 32'({9'd4, 9'd8, 9'd12}));
    check("flush_x0_taps", 32'((fs_log.size() > 2) ? fs_log[2] : '1), 32'({9'd5, 9'd9, 9'd9}));
    check("flush_x3_taps", 32'((fe_log.size() > 2) ? fe_log[2] : '1), 32'({9'd8, 9'd12, 9'd12}));
    check("first_start_latency", 32'((fs_cyc.size() > 0) ? fs_cyc[0] - r1p0 : -1), 32'd1);
    check("done_after_last_end",
          32'((done_cyc.size() > 0 && fe_cyc.size() > 2) ? done_cyc[0] - fe_cyc[2] : -1), 32'd1);
    check("clean_err", 32'(err_o), 32'd0);
    check("clean_idle", 32'(busy_o), 32'd0);

    // pix_valid drops for one cycle at row 1, x=2.
    send_frame(1, 1, 2, TAIL);
    check("drop_err_sticky", 32'(err_o), 32'd1);
    check("drop_idle", 32'(busy_o), 32'd0);

    // New frame from IDLE clears err, then gets aborted at row 1, x=1.
    drive_pix(1'b1, pv(3, 0, 0));
    drive_pix(1'b0, pv(3, 0, 1));
    check("start_clears_err", 32'(err_o), 32'd0);
    check("start_busy", 32'(busy_o), 32'd1);
    drive_pix(1'b0, pv(3, 0, 2));
    drive_pix(1'b0, pv(3, 0, 3));
    drive_idle(LINE_GAP);
    drive_pix(1'b0, pv(3, 1, 0));
    send_frame(4, -1, -1, TAIL);
    check("abort_err", 32'(err_o), 32'd1);
    check("abort_new_frame_idle", 32'(busy_o), 32'd0);

    // Reset in the middle of the flush line.
    send_frame(5, -1, -1, 1);
    repeat (FG + 1) @(posedge clk);
    #1;
    check("in_flush_busy", 32'(busy_o), 32'd1);
    check("in_flush_start", 32'(filter_start_o), 32'd1);
    rst_n = 1'b0;
    exp_m.delete();
    done_m.delete();
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_fs", 32'(filter_start_o), 32'd0);
    check("rst_in1", 32'(in1_o), 32'd0);
    check("rst_in2", 32'(in2_o), 32'd0);
    check("rst_in3", 32'(in3_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_idle(2);
    send_frame(6, -1, -1, TAIL);
    check("post_rst_err", 32'(err_o), 32'd0);
    check("post_rst_idle", 32'(busy_o), 32'd0);

    // Stray pixel while IDLE is ignored but flagged.
    drive_pix(1'b0, 9'h55);
    drive_idle(2);
    check("idle_pix_err", 32'(err_o), 32'd1);
    check("idle_pix_idle", 32'(busy_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
